fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of `decoder`; replaces the bare `PC` + `inst_mem` pairing.
- Owns the fetch PC, issues pipelined word reads to instruction memory, and buffers returned words in a small in-order queue.
- Presents each buffered word with its PC to the decoder under a valid/ready handshake.
- On a `jump_controller` redirect, flushes the queue and squashes in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // One queued fetch result: the instruction word and the PC it was read from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Redirect targets are forced to word alignment.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched words with their PCs; head read straight from storage flops.
// Latency: a word pushed at edge N is visible at the head from N+1 (no bypass).
// Backpressure: none internally; the caller's credit scheme keeps pushes off a full queue.
// Ports: push_i/push_dat_i write, pop_i advance head, flush_i empties (wins over push/pop),
//        head_dat_o head entry, count_o occupancy, empty_o queue empty.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_dat_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues pipelined reads, queues words for the decoder.
// Latency: request to inst_valid is memory latency + 1 cycle.
// Backpressure: reads are issued only while queued + outstanding words < DEPTH; decoder stalls via inst_ready.
// Ports: imem_* read request/response channel, jump_flag/jump_target redirect,
//        inst_valid/inst/inst_pc/inst_ready decoder handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q,  resp_pc_d;
    logic [CW-1:0] outst_q,    outst_d;
    logic [CW-1:0] drop_q,     drop_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    fetch_entry_t  head_dat;
    fetch_entry_t  push_dat;
    logic          push;
    logic          pop;
    logic          accept;
    logic [CW:0]   credit_used;

    // Every outstanding read owns a queue slot, so a response can never find the queue full.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
    // rst_n gating keeps the request low while reset is held, yet lets the first
    // request go out in the very first cycle after release.
    assign imem_req  = rst_n && !jump_flag && (credit_used < CREDITS);
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(accept) - CW'(imem_rvalid);
        push       = 1'b0;
        push_dat   = '{pc: resp_pc_q, word: imem_rdata};

        if (jump_flag) begin
            // Everything still in flight belongs to the old stream; a response
            // arriving this very cycle is discarded here and not counted again.
            fetch_pc_d = align_pc(jump_target);
            resp_pc_d  = align_pc(jump_target);
            drop_d     = outst_q - CW'(imem_rvalid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (imem_rvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    assign pop = !fifo_empty && inst_ready;

    // A pop handshaked in the redirect cycle is still consumed by the decoder;
    // the flush simply removes it along with the rest.
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (jump_flag),
        .head_dat_o (head_dat),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = head_dat.word;
    assign inst_pc    = head_dat.pc;

    a_no_rvalid_when_full : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (fifo_count == CW'(DEPTH)))
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with configurable latency/ready, stream reference model.
// Latency: n/a.
// Backpressure: driven by the bench (imem_ready patterns, inst_ready).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_target = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    fetch_unit #(.RESET_PC(RESET_PC_DEFAULT), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .jump_flag   (jump_flag),
        .jump_target (jump_target),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc, lat, ready_mode, stall_cnt;
    int          nacc, npop, first_acc, first_pop;
    logic [31:0] exp_pc, exp_addr, prev_addr, last_acc_addr, last_pop_pc, first_pop_pc;
    logic        prev_jump, prev_stall, rel_pending = 1'b0;

    // Memory contents: a fixed scramble of the address, nonzero at address 0.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic do_reset(input int l, input int rm);
        rst_n = 1'b0;
        jump_flag = 1'b0; jump_target = '0; inst_ready = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        memq.delete();
        lat = l; ready_mode = rm; stall_cnt = 0; cyc = 0;
        exp_pc = RESET_PC_DEFAULT; exp_addr = RESET_PC_DEFAULT;
        nacc = 0; npop = 0; first_acc = -1; first_pop = -1;
        prev_jump = 1'b0; prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rel_pending = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, then evaluate the
    // handshakes that the next rising edge will commit.
    task automatic step(input logic jf, input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        if (rel_pending) begin rst_n = 1'b1; rel_pending = 1'b0; end
        jump_flag = jf; jump_target = tgt; inst_ready = rdy;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1; imem_rdata = word_of(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
        end
        case (ready_mode)
            1:       imem_ready = ($urandom_range(0, 2) != 0);
            2:       if (imem_addr == 32'h8 && stall_cnt < 2) begin imem_ready = 1'b0; stall_cnt++; end
                     else imem_ready = 1'b1;
            default: imem_ready = 1'b1;
        endcase
        #1;
        if (prev_jump) begin
            tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL valid_after_jump: got %b want 0 (cyc %0d)", inst_valid, cyc); end
        end
        if (prev_stall) begin
            tests++; if (imem_addr !== prev_addr) begin fails++; $display("FAIL stall_addr_hold: got %h want %h", imem_addr, prev_addr); end
        end
        if (inst_valid && inst_ready) begin
            tests++; if (inst_pc !== exp_pc) begin fails++; $display("FAIL pop_pc: got %h want %h (cyc %0d)", inst_pc, exp_pc, cyc); end
            tests++; if (inst !== word_of(exp_pc)) begin fails++; $display("FAIL pop_word: got %h want %h", inst, word_of(exp_pc)); end
            if (npop == 0) begin first_pop = cyc; first_pop_pc = inst_pc; end
            last_pop_pc = inst_pc;
            npop++;
            exp_pc = exp_pc + 32'd4;
        end
        if (jf) begin
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL req_in_jump: got %b want 0", imem_req); end
            exp_pc   = {tgt[31:2], 2'b00};
            exp_addr = {tgt[31:2], 2'b00};
        end
        if (imem_req && imem_ready) begin
            tests++; if (imem_addr !== exp_addr) begin fails++; $display("FAIL fetch_addr: got %h want %h (cyc %0d)", imem_addr, exp_addr, cyc); end
            if (nacc == 0) first_acc = cyc;
            last_acc_addr = imem_addr;
            nacc++;
            exp_addr = exp_addr + 32'd4;
            memq.push_back('{addr: imem_addr, due: cyc + lat});
            tests++; if (memq.size() > DEPTH) begin fails++; $display("FAIL outstanding_bound: got %0d want <=%0d", memq.size(), DEPTH); end
        end
        if (imem_rvalid) void'(memq.pop_front());
        prev_jump  = jf;
        prev_stall = imem_req && !imem_ready && !jf;
        prev_addr  = imem_addr;
        cyc++;
    endtask

    task automatic test_reset();
        do_reset(1, 0);
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== RESET_PC_DEFAULT) begin fails++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC_DEFAULT); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst: got %h want 0", inst); end
        tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
        tests++; if (first_acc !== 0) begin fails++; $display("FAIL stream_first_acc: got %0d want 0", first_acc); end
        tests++; if (first_pop - first_acc !== 2) begin fails++; $display("FAIL stream_first_valid: got %0d want 2", first_pop - first_acc); end
        tests++; if (nacc !== 20) begin fails++; $display("FAIL stream_accepts: got %0d want 20", nacc); end
        tests++; if (npop !== 18) begin fails++; $display("FAIL stream_pops: got %0d want 18", npop); end
    endtask

    task automatic test_backpressure();
        do_reset(1, 0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        tests++; if (nacc !== DEPTH) begin fails++; $display("FAIL bp_accepts: got %0d want %0d", nacc, DEPTH); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_full: got %b want 1", inst_valid); end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        tests++; if (npop !== 12) begin fails++; $display("FAIL bp_pops: got %0d want 12", npop); end
        tests++; if (nacc !== 15) begin fails++; $display("FAIL bp_resume_accepts: got %0d want 15", nacc); end
    endtask

    task automatic test_redirect_lat3();
        do_reset(3, 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        tests++; if (first_pop_pc !== 32'h100) begin fails++; $display("FAIL lat3_first_pc: got %h want 00000100", first_pop_pc); end
        tests++; if (first_pop !== 8) begin fails++; $display("FAIL lat3_first_pop_cyc: got %0d want 8", first_pop); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset(1, 0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h202, 1'b1);
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL same_cyc_valid: got %b want 1", inst_valid); end
        tests++; if (npop !== 5) begin fails++; $display("FAIL same_cyc_pops: got %0d want 5", npop); end
        step(1'b0, '0, 1'b1);
        tests++; if (last_acc_addr !== 32'h200) begin fails++; $display("FAIL same_cyc_next_addr: got %h want 00000200", last_acc_addr); end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        tests++; if (last_pop_pc !== 32'h208) begin fails++; $display("FAIL same_cyc_last_pc: got %h want 00000208", last_pop_pc); end
    endtask

    task automatic test_stall_random();
        do_reset(1, 2);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        tests++; if (nacc !== 10) begin fails++; $display("FAIL stall_accepts: got %0d want 10", nacc); end
        do_reset(2, 1);
        for (int i = 0; i < 300; i++) begin
            if (i == 150) step(1'b1, 32'hFFFF_FFF9, $urandom_range(0, 1) == 1);
            else if ($urandom_range(0, 19) == 0) step(1'b1, $urandom, $urandom_range(0, 1) == 1);
            else step(1'b0, '0, $urandom_range(0, 3) != 0);
        end
        tests++; if (npop < 50) begin fails++; $display("FAIL random_progress: got %0d want >=50", npop); end
    endtask

    task automatic test_reset_mid();
        do_reset(1, 0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %b want 1", inst_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mid_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== RESET_PC_DEFAULT) begin fails++; $display("FAIL mid_addr: got %h want %h", imem_addr, RESET_PC_DEFAULT); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", inst_valid); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL mid_inst: got %h want 0", inst); end
        tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL mid_pc: got %h want 0", inst_pc); end
        do_reset(1, 0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        tests++; if (first_acc !== 0) begin fails++; $display("FAIL mid_restart_acc: got %0d want 0", first_acc); end
        tests++; if (npop !== 8) begin fails++; $display("FAIL mid_restart_pops: got %0d want 8", npop); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_lat3();
        test_redirect_same_cycle();
        test_stall_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
